// File: rtl/ticket_pkg.sv
// ticket_pkg -- shared definitions for the ticket dispatcher.
//   state_t        : dispatcher FSM states (IDLE, OFFER)
//   *_DEF          : default values for the N_LANES / PEND_W / CNT_W parameters
package ticket_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int N_LANES_DEF = 4;
  localparam int PEND_W_DEF  = 2;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin search.
// Returns the first requesting lane found searching upward from ptr,
// wrapping past the top lane back to lane 0.
// Ports:
//   req    [N_LANES-1:0]        request vector (lane has pending tickets)
//   ptr    [clog2(N_LANES)-1:0] lane the search starts at
//   winner [clog2(N_LANES)-1:0] selected lane (0 when nothing requests)
//   any                         at least one request present
module rr_arbiter #(
  parameter int N_LANES = 4
) (
  input  logic [N_LANES-1:0]         req,
  input  logic [$clog2(N_LANES)-1:0] ptr,
  output logic [$clog2(N_LANES)-1:0] winner,
  output logic                       any
);

  localparam int LW = $clog2(N_LANES);

  // cand[k] is the lane visited k steps after ptr in the search order.
  logic [LW-1:0] cand [N_LANES];

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_cand
      assign cand[gi] = LW'((int'(ptr) + gi) % N_LANES);
    end
  endgenerate

  // Scan from the far end back towards ptr so the closest requester
  // is the last (and therefore winning) assignment.
  always_comb begin
    winner = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner = cand[k];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ticket_dispatch.sv
// ticket_dispatch -- collects speed-check tickets from N_LANES lanes,
// keeps a saturating pending count per lane and offers one ticket at a
// time to a printer with a valid/ready handshake, granting lanes in
// round-robin order.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   ticket_req [N]      per-lane ticket pulse (one ticket per high cycle)
//   out_valid / out_lane / out_ready   ticket offer handshake
//   ovf [N], ovf_clr    sticky per-lane pending-overflow flags and clear
//   busy                any pending ticket or an offer in progress
//   total_cnt [N*CNT_W] per-lane accepted totals, lane 0 in LSBs
// Build option: define TICKET_TOTAL_EN to implement the saturating
// per-lane totals; otherwise total_cnt is tied to zero.
module ticket_dispatch
  import ticket_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int PEND_W  = PEND_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_LANES-1:0]         ticket_req,
  output logic                       out_valid,
  output logic [$clog2(N_LANES)-1:0] out_lane,
  input  logic                       out_ready,
  output logic [N_LANES-1:0]         ovf,
  input  logic                       ovf_clr,
  output logic                       busy,
  output logic [N_LANES*CNT_W-1:0]   total_cnt
);

  localparam int LW = $clog2(N_LANES);

  state_t          state_reg;
  logic            out_valid_reg;
  logic [LW-1:0]   out_lane_reg;
  logic [LW-1:0]   ptr_reg;
  logic [N_LANES-1:0] pend_nz;
  logic [LW-1:0]   win;
  logic            any_pend;
  logic            xfer;

  assign xfer = out_valid_reg & out_ready;

  // Per-lane pending counter and sticky overflow flag.
  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [PEND_W-1:0] pend_reg;
      logic              ovf_bit_reg;
      logic              inc;
      logic              dec;
      logic              ovf_evt;

      assign inc     = ticket_req[gi];
      assign dec     = xfer && (out_lane_reg == LW'(gi));
      assign ovf_evt = inc && !dec && (&pend_reg);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pend_reg    <= '0;
          ovf_bit_reg <= 1'b0;
        end else begin
          if (inc && !dec && !(&pend_reg)) begin
            pend_reg <= pend_reg + 1'b1;
          end else if (dec && !inc) begin
            pend_reg <= pend_reg - 1'b1;
          end
          // A fresh overflow beats a simultaneous clear.
          if (ovf_evt) begin
            ovf_bit_reg <= 1'b1;
          end else if (ovf_clr) begin
            ovf_bit_reg <= 1'b0;
          end
        end
      end

      assign pend_nz[gi] = |pend_reg;
      assign ovf[gi]     = ovf_bit_reg;

`ifdef TICKET_TOTAL_EN
      logic [CNT_W-1:0] tot_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tot_reg <= '0;
        end else if (dec && !(&tot_reg)) begin
          tot_reg <= tot_reg + 1'b1;
        end
      end

      assign total_cnt[gi*CNT_W +: CNT_W] = tot_reg;
`else
      assign total_cnt[gi*CNT_W +: CNT_W] = '0;
`endif
    end
  endgenerate

  // The arbiter sees pending counts as registered before this edge, so
  // requests arriving at the grant edge cannot influence that grant.
  rr_arbiter #(
    .N_LANES(N_LANES)
  ) u_arb (
    .req    (pend_nz),
    .ptr    (ptr_reg),
    .winner (win),
    .any    (any_pend)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_lane_reg  <= '0;
      ptr_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_pend) begin
            state_reg     <= OFFER;
            out_valid_reg <= 1'b1;
            out_lane_reg  <= win;
            ptr_reg       <= (win == LW'(N_LANES - 1)) ? '0 : win + 1'b1;
          end
        end
        OFFER: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_lane  = out_lane_reg;
  assign busy      = (|pend_nz) || (state_reg != IDLE);

endmodule

// File: tb/tb_ticket_dispatch.sv
module tb_ticket_dispatch;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ticket_req = '0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [1:0] out_lane;
  logic [3:0] ovf;
  logic       busy;
  logic [7:0] total_cnt;

  int checks = 0;
  int failures = 0;

  ticket_dispatch #(.N_LANES(N), .PEND_W(PW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ticket_req(ticket_req),
    .out_valid (out_valid),
    .out_lane  (out_lane),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .total_cnt (total_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h @%0t", name, act, $time);
    end
  endtask

  // Drive inputs at a falling edge and advance to the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic clr);
    ticket_req = r;
    out_ready  = rdy;
    ovf_clr    = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    ticket_req = '0;
    out_ready  = 1'b0;
    ovf_clr    = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_pend [N];
  int m_tot  [N];
  bit m_ovf  [N];
  bit m_valid;
  int m_lane;
  int m_ptr;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_tot[i] = 0; m_ovf[i] = 0;
    end
    m_valid = 0; m_lane = 0; m_ptr = 0;
  endtask

  task automatic m_step(input logic [3:0] r, input logic rdy, input logic clr);
    int mx;
    int w;
    bit xf;
    mx = (1 << PW) - 1;
    xf = m_valid && rdy;
    w  = -1;
    if (!m_valid) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && m_pend[(m_ptr + k) % N] > 0) w = (m_ptr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit inc, dec, ev;
      inc = r[i];
      dec = xf && (m_lane == i);
      ev  = 0;
      if (inc && !dec) begin
        if (m_pend[i] == mx) ev = 1;
        else m_pend[i]++;
      end else if (dec && !inc) begin
        m_pend[i]--;
      end
      if (ev) m_ovf[i] = 1;
      else if (clr) m_ovf[i] = 0;
      if (dec && m_tot[i] < (1 << CW) - 1) m_tot[i]++;
    end
    if (m_valid) begin
      if (rdy) m_valid = 0;
    end else if (w >= 0) begin
      m_valid = 1;
      m_lane  = w;
      m_ptr   = (w + 1) % N;
    end
  endtask

  function automatic logic [3:0] m_ovf_vec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = m_valid;
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] m_tot_vec();
    logic [7:0] v;
    v = '0;
`ifdef TICKET_TOTAL_EN
    for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_tot[i]);
`endif
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] el;
    logic [3:0] eo;
    logic       eb;
  } vec_t;

  vec_t tbl [22];
  logic [7:0] exp_tot;

  initial begin
    // all four lanes at once, printer always ready: grants 0,1,2,3
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    // single pulse on lane 2
    tbl[9]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    // lane 1 pulsed four times with printer stalled -> overflow
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
    tbl[14] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
    tbl[15] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
    // drain: exactly three lane-1 transfers
    tbl[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
    tbl[19] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[20] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1};
    tbl[21] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0};

    // ---- reset state ----
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_lane",  32'(out_lane),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_total", 32'(total_cnt), 32'd0);

    // ---- table ----
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].req, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_lane", i), 32'(out_lane), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_ovf", i),  32'(ovf),  32'(tbl[i].eo));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
    end

    // ---- overflow beats clear; inc+dec on a full lane ----
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("ovf0_set", 32'(ovf), 32'h1);
    cyc(4'b0001, 1'b0, 1'b1);
    chk("ovf0_wins_clr", 32'(ovf), 32'h1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("ovf0_cleared", 32'(ovf), 32'h0);
    cyc(4'b0001, 1'b1, 1'b0);
    chk("incdec_no_ovf", 32'(ovf), 32'h0);
    chk("incdec_xfer", 32'(out_valid), 32'd0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("full_regrant_valid", 32'(out_valid), 32'd1);
    chk("full_regrant_lane", 32'(out_lane), 32'd0);
    chk("full_again_ovf", 32'(ovf), 32'h1);

    // ---- stall in OFFER for 10 cycles, then one transfer ----
    do_reset();
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'b0, 1'b0);
      chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_lane", i),  32'(out_lane),  32'd2);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    chk("stall_xfer_valid", 32'(out_valid), 32'd0);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("stall_single_xfer", 32'(out_valid), 32'd0);
    chk("stall_idle_busy", 32'(busy), 32'd0);

    // ---- reset during OFFER ----
    do_reset();
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_lane",  32'(out_lane),  32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    cyc(4'b1001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("post_rst_ptr_valid", 32'(out_valid), 32'd1);
    chk("post_rst_ptr_lane",  32'(out_lane),  32'd0);

    // ---- five transfers on lane 3: totals saturate ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
    end
`ifdef TICKET_TOTAL_EN
    exp_tot = 8'hC0;
`else
    exp_tot = 8'h00;
`endif
    chk("total_lane3_sat", 32'(total_cnt), 32'(exp_tot));
    chk("total_idle_busy", 32'(busy), 32'd0);

    // ---- randomized run against the reference model ----
    do_reset();
    m_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      logic rdy, clr;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc(r, rdy, clr);
      m_step(r, rdy, clr);
      chk($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(m_valid));
      if (m_valid) chk($sformatf("rnd%0d_lane", c), 32'(out_lane), 32'(m_lane));
      chk($sformatf("rnd%0d_ovf", c),   32'(ovf),       32'(m_ovf_vec()));
      chk($sformatf("rnd%0d_busy", c),  32'(busy),      32'(m_busy()));
      chk($sformatf("rnd%0d_total", c), 32'(total_cnt), 32'(m_tot_vec()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
